// File: rtl/ascon_pkg.sv
// rtl/ascon_pkg.sv - shared ASCON constants, state type and round-constant function
package ascon_pkg;

    localparam int ASCON_PA_ROUNDS = 12;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Round constant for round index i: upper nibble is the complement of the lower.
    function automatic logic [7:0] ascon_rc(input logic [3:0] i);
        return {~i, i};
    endfunction

endpackage

// File: rtl/ascon_rc_lane.sv
// rtl/ascon_rc_lane.sv - one unrolled lane: constant for round idx+K, blanked when idle
module ascon_rc_lane
    import ascon_pkg::*;
#(
    parameter int K = 0
) (
    input  logic [3:0] idx,
    input  logic       busy,
    output logic [7:0] rc
);

    localparam logic [3:0] OFF = 4'(K);

    logic [3:0] lane_idx;

    // Legal parameters keep idx+K within 0..11 whenever busy is high, so no wrap.
    assign lane_idx = idx + OFF;

    // Zero the constant outside RUN so nothing round-dependent leaks while idle.
    always_comb begin
        rc = busy ? ascon_rc(lane_idx) : 8'h00;
    end

endmodule

// File: rtl/ascon_round_constant_ctrl.sv
// rtl/ascon_round_constant_ctrl.sv - round sequencer and unrolled round-constant generator
module ascon_round_constant_ctrl
    import ascon_pkg::*;
#(
    parameter int UNROLL    = 2,
    parameter int PB_ROUNDS = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                sel_pb,
    input  logic                hold,
    output logic [8*UNROLL-1:0] constt,
    output logic [3:0]          round_idx,
    output logic                busy,
    output logic                last,
    output logic                done
);

    // Reject illegal parameter combinations at elaboration.
    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 3 || UNROLL == 4 || UNROLL == 6) ||
        !(PB_ROUNDS == 6 || PB_ROUNDS == 8) ||
        (ASCON_PA_ROUNDS % UNROLL) != 0 || (PB_ROUNDS % UNROLL) != 0) begin : g_bad_param
        $error("ascon_round_constant_ctrl: illegal UNROLL/PB_ROUNDS combination");
    end

    localparam logic [3:0] PA_START = 4'd0;
    localparam logic [3:0] PB_START = 4'(ASCON_PA_ROUNDS - PB_ROUNDS);
    localparam logic [3:0] STEP     = 4'(UNROLL);
    localparam logic [3:0] LAST_IDX = 4'(ASCON_PA_ROUNDS - UNROLL);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] idx_q;
    logic       done_q;
    logic       at_last;

    // The final group is the one whose lanes end exactly at round 11.
    assign at_last = (idx_q == LAST_IDX);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: start leaves IDLE, consuming the final group without hold returns.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (!hold && at_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Round index and done pulse; sel_pb only matters on the accepting cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q  <= 4'd0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == IDLE) begin
                if (start) begin
                    idx_q <= sel_pb ? PB_START : PA_START;
                end
            end else if (!hold) begin
                if (at_last) begin
                    idx_q  <= 4'd0;
                    done_q <= 1'b1;
                end else begin
                    idx_q <= idx_q + STEP;
                end
            end
        end
    end

    // Status outputs decoded from the current state.
    always_comb begin
        busy = (state_q == RUN);
        last = (state_q == RUN) && at_last;
    end

    assign round_idx = idx_q;
    assign done      = done_q;

    for (genvar k = 0; k < UNROLL; k++) begin : g_lane
        ascon_rc_lane #(.K(k)) u_lane (
            .idx  (idx_q),
            .busy (busy),
            .rc   (constt[8*k +: 8])
        );
    end

endmodule

// File: tb/tb_ascon_round_constant_ctrl.sv
// tb/tb_ascon_round_constant_ctrl.sv - bench for ascon_round_constant_ctrl in three configurations
module tb_ascon_round_constant_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic sel_pb = 1'b0;
    logic hold = 1'b0;

    always #5 clk = ~clk;

    logic [15:0] c_a;
    logic [23:0] c_b;
    logic [7:0]  c_c;
    logic [3:0]  i_a, i_b, i_c;
    logic        b_a, b_b, b_c, l_a, l_b, l_c, d_a, d_b, d_c;

    ascon_round_constant_ctrl #(.UNROLL(2), .PB_ROUNDS(6)) dut_a (
        .clk(clk), .rst(rst), .start(start), .sel_pb(sel_pb), .hold(hold),
        .constt(c_a), .round_idx(i_a), .busy(b_a), .last(l_a), .done(d_a));

    ascon_round_constant_ctrl #(.UNROLL(3), .PB_ROUNDS(6)) dut_b (
        .clk(clk), .rst(rst), .start(start), .sel_pb(sel_pb), .hold(hold),
        .constt(c_b), .round_idx(i_b), .busy(b_b), .last(l_b), .done(d_b));

    ascon_round_constant_ctrl #(.UNROLL(1), .PB_ROUNDS(8)) dut_c (
        .clk(clk), .rst(rst), .start(start), .sel_pb(sel_pb), .hold(hold),
        .constt(c_c), .round_idx(i_c), .busy(b_c), .last(l_c), .done(d_c));

    // Observed outputs per configuration: {busy, last, done, round_idx, constt[47:0]}.
    logic [54:0] a_vec [3];
    assign a_vec[0] = {b_a, l_a, d_a, i_a, 32'b0, c_a};
    assign a_vec[1] = {b_b, l_b, d_b, i_b, 24'b0, c_b};
    assign a_vec[2] = {b_c, l_c, d_c, i_c, 40'b0, c_c};

    // Reference model: rounds still to present, and the pending done pulse.
    int U  [3] = '{2, 3, 1};
    int PB [3] = '{6, 6, 8};
    int rem [3];
    bit m_done [3];

    int n_checks = 0;
    int n_pass   = 0;

    function automatic logic [47:0] exp_const(input int c);
        logic [47:0] v;
        int first;
        int r;
        v = '0;
        if (rem[c] != 0) begin
            first = 12 - rem[c];
            for (int k = 0; k < U[c]; k++) begin
                r = first + k;
                v = v | (48'((15 - r) * 16 + r) << (8 * k));
            end
        end
        return v;
    endfunction

    function automatic logic [54:0] exp_vec(input int c);
        logic       e_busy;
        logic       e_last;
        logic [3:0] e_idx;
        e_busy = (rem[c] != 0);
        e_last = (rem[c] == U[c]);
        e_idx  = e_busy ? 4'(12 - rem[c]) : 4'd0;
        return {e_busy, e_last, 1'(m_done[c]), e_idx, exp_const(c)};
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            rem[c]    = 0;
            m_done[c] = 1'b0;
        end
    endtask

    // Drive inputs, advance one clock edge, update the model, sample after the edge.
    task automatic tick(input logic s, input logic p, input logic h);
        start  = s;
        sel_pb = p;
        hold   = h;
        @(posedge clk);
        for (int c = 0; c < 3; c++) begin
            m_done[c] = 1'b0;
            if (rem[c] == 0) begin
                if (s) rem[c] = p ? PB[c] : 12;
            end else if (!h) begin
                rem[c] = rem[c] - U[c];
                if (rem[c] == 0) m_done[c] = 1'b1;
            end
        end
        #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        #1;
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (a_vec[c] !== 55'd0)
                $display("FAIL reset cfg%0d got %h want %h", c, a_vec[c], 55'd0);
            else n_pass++;
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_pa_schedule();
        logic [15:0] tab_a [6] = '{16'he1f0, 16'hc3d2, 16'ha5b4, 16'h8796, 16'h6978, 16'h4b5a};
        logic [23:0] tab_b [4] = '{24'hd2e1f0, 24'ha5b4c3, 24'h788796, 24'h4b5a69};
        tick(1'b1, 1'b0, 1'b0);
        for (int n = 0; n < 14; n++) begin
            for (int c = 0; c < 3; c++) begin
                n_checks++;
                if (a_vec[c] !== exp_vec(c))
                    $display("FAIL pa_seq cfg%0d cyc%0d got %h want %h", c, n, a_vec[c], exp_vec(c));
                else n_pass++;
            end
            if (n < 6) begin
                n_checks++;
                if (c_a !== tab_a[n] || l_a !== (n == 5))
                    $display("FAIL pa_table_u2 cyc%0d got %h/%b want %h/%b", n, c_a, l_a, tab_a[n], n == 5);
                else n_pass++;
            end
            if (n < 4) begin
                n_checks++;
                if (c_b !== tab_b[n])
                    $display("FAIL pa_table_u3 cyc%0d got %h want %h", n, c_b, tab_b[n]);
                else n_pass++;
            end
            if (n == 6) begin
                n_checks++;
                if (d_a !== 1'b1 || b_a !== 1'b0)
                    $display("FAIL pa_done_u2 got done=%b busy=%b want 1/0", d_a, b_a);
                else n_pass++;
            end
            tick(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_pb_schedule();
        logic [15:0] tab_a [3] = '{16'h8796, 16'h6978, 16'h4b5a};
        tick(1'b1, 1'b1, 1'b0);
        for (int n = 0; n < 10; n++) begin
            for (int c = 0; c < 3; c++) begin
                n_checks++;
                if (a_vec[c] !== exp_vec(c))
                    $display("FAIL pb_seq cfg%0d cyc%0d got %h want %h", c, n, a_vec[c], exp_vec(c));
                else n_pass++;
            end
            if (n < 3) begin
                n_checks++;
                if (c_a !== tab_a[n])
                    $display("FAIL pb_table_u2 cyc%0d got %h want %h", n, c_a, tab_a[n]);
                else n_pass++;
            end
            if (n == 0) begin
                n_checks++;
                if (c_c !== 8'hb4)
                    $display("FAIL pb8_first got %h want b4", c_c);
                else n_pass++;
            end
            tick(1'b0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_hold();
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 3; n++) begin
            n_checks++;
            if (c_a !== 16'hc3d2 || i_a !== 4'd2 || b_a !== 1'b1)
                $display("FAIL hold_group2 cyc%0d got %h idx=%0d want c3d2 idx=2", n, c_a, i_a);
            else n_pass++;
            if (n < 2) tick(1'b0, 1'b0, 1'b1);
        end
        for (int n = 0; n < 14; n++) begin
            for (int c = 0; c < 3; c++) begin
                n_checks++;
                if (a_vec[c] !== exp_vec(c))
                    $display("FAIL hold_seq cfg%0d cyc%0d got %h want %h", c, n, a_vec[c], exp_vec(c));
                else n_pass++;
            end
            tick(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        bool_restarted: begin end
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        for (int n = 0; n < 40; n++) begin
            for (int c = 0; c < 3; c++) begin
                n_checks++;
                if (a_vec[c] !== exp_vec(c))
                    $display("FAIL b2b_seq cfg%0d cyc%0d got %h want %h", c, n, a_vec[c], exp_vec(c));
                else n_pass++;
            end
            if (d_a === 1'b1 && n < 10) begin
                tick(1'b1, 1'b0, 1'b0);
                n_checks++;
                if (b_a !== 1'b1 || i_a !== 4'd0 || c_a !== 16'he1f0)
                    $display("FAIL b2b_restart got busy=%b idx=%0d c=%h want 1/0/e1f0", b_a, i_a, c_a);
                else n_pass++;
            end else begin
                tick(1'b0, 1'b0, 1'b0);
            end
        end
    endtask

    task automatic test_async_reset();
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (a_vec[c] !== 55'd0)
                $display("FAIL async_reset cfg%0d got %h want 0", c, a_vec[c]);
            else n_pass++;
        end
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 3; n++) begin
            tick(1'b0, 1'b0, 1'b0);
            n_checks++;
            if (d_a !== 1'b0 || d_b !== 1'b0 || d_c !== 1'b0 || b_a !== 1'b0)
                $display("FAIL no_done_after_reset cyc%0d got %b%b%b want 000", n, d_a, d_b, d_c);
            else n_pass++;
        end
        tick(1'b1, 1'b0, 1'b0);
        for (int n = 0; n < 14; n++) begin
            for (int c = 0; c < 3; c++) begin
                n_checks++;
                if (a_vec[c] !== exp_vec(c))
                    $display("FAIL post_reset_seq cfg%0d cyc%0d got %h want %h", c, n, a_vec[c], exp_vec(c));
                else n_pass++;
            end
            tick(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_random();
        logic s, p, h;
        for (int n = 0; n < 400; n++) begin
            s = ($urandom_range(3) == 0);
            p = 1'($urandom_range(1));
            h = ($urandom_range(2) == 0);
            tick(s, p, h);
            for (int c = 0; c < 3; c++) begin
                n_checks++;
                if (a_vec[c] !== exp_vec(c))
                    $display("FAIL random cfg%0d cyc%0d got %h want %h", c, n, a_vec[c], exp_vec(c));
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_pa_schedule();
        test_pb_schedule();
        test_hold();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
